// File: rtl/ofs_fim_if_pkg.sv
// Shared types for the IRQ response path: the AXIS response beat, the
// field position of the vector id inside tdata, and the per-vector
// tracker state encoding.
package ofs_fim_if_pkg;

  localparam int IRQ_RSP_DW     = 16;
  localparam int IRQ_RSP_ID_LSB = 0;

  typedef struct packed {
    logic                  tvalid;
    logic [IRQ_RSP_DW-1:0] tdata;
  } t_axis_irq_rsp;

  typedef enum logic {
    IRQ_IDLE    = 1'b0,
    IRQ_PENDING = 1'b1
  } t_irq_trk_state;

  // Width of a vector id; a single-vector tracker still carries one id bit.
  function automatic int irq_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_rsp_tracker_if.sv
// Response-stream bundle between the IRQ response pipeline register
// (master) and the tracker (slave). The tracker never backpressures, so
// its ready is a separate top-level output rather than part of the bundle.
interface irq_rsp_tracker_if;
  import ofs_fim_if_pkg::*;

  t_axis_irq_rsp rsp;

  modport master (output rsp);
  modport slave  (input  rsp);

endinterface

// File: rtl/irq_rsp_vec_tracker.sv
// One interrupt vector: IDLE/PENDING state, a saturating age timer, a
// one-cycle ack pulse on retirement by response, and a timeout event that
// is high during the cycle the request expires.
module irq_rsp_vec_tracker
  import ofs_fim_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_pending,
  output logic o_ack,
  output logic o_timeout_evt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  t_irq_trk_state   r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_ack;
  logic             w_expire;

  // A response in the expiry cycle wins, so the timeout is masked by clr.
  assign w_expire      = (r_state == IRQ_PENDING) && (r_timer == TMR_LAST);
  assign o_timeout_evt = w_expire & ~i_clr;
  assign o_pending     = (r_state == IRQ_PENDING);
  assign o_ack         = r_ack;

  // Vector FSM with its age timer and registered ack pulse.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IRQ_IDLE;
      r_timer <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IRQ_IDLE: begin
          if (i_set) begin
            r_state <= IRQ_PENDING;
            r_timer <= '0;
          end
        end
        IRQ_PENDING: begin
          if (i_clr) begin
            r_state <= IRQ_IDLE;
            r_ack   <= 1'b1;
          end else if (w_expire) begin
            r_state <= IRQ_IDLE;
          end else if (r_timer != TMR_LAST) begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: begin
          r_state <= IRQ_IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/irq_rsp_tracker.sv
// Terminal consumer of the AXIS IRQ response stream. Tracks one
// outstanding request per vector, acks matched responses one cycle after
// the handshake, and keeps sticky unexpected-response and timeout errors.
module irq_rsp_tracker
  import ofs_fim_if_pkg::*;
#(
  parameter  int NUM_IRQS       = 4,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int ID_W           = irq_id_width(NUM_IRQS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  irq_req_valid,
  input  logic [ID_W-1:0]       irq_req_id,
  output logic                  irq_req_ready,
  irq_rsp_tracker_if.slave      s_if,
  output logic                  s_if_tready,
  output logic [NUM_IRQS-1:0]   irq_ack,
  output logic [NUM_IRQS-1:0]   irq_pending,
  input  logic                  err_clr,
  output logic                  err_unexp_rsp,
  output logic [IRQ_RSP_DW-1:0] err_unexp_id,
  output logic [NUM_IRQS-1:0]   err_timeout
);

  logic                  r_tready;
  logic                  r_err_unexp;
  logic [IRQ_RSP_DW-1:0] r_err_id;
  logic [NUM_IRQS-1:0]   r_err_timeout;

  logic [NUM_IRQS-1:0]   w_pending;
  logic [NUM_IRQS-1:0]   w_ack;
  logic [NUM_IRQS-1:0]   w_timeout_evt;
  logic [NUM_IRQS-1:0]   w_set;
  logic [NUM_IRQS-1:0]   w_clr;

  logic                  w_req_in_range;
  logic                  w_req_fire;
  logic [ID_W-1:0]       w_rsp_id;
  logic                  w_rsp_in_range;
  logic                  w_rsp_fire;
  logic                  w_rsp_match;
  logic                  w_rsp_unexp;

  // Ready looks only at registered pending state, so a vector retired this
  // cycle can be re-requested no earlier than the next one.
  assign w_req_in_range = (32'(irq_req_id) < 32'(NUM_IRQS));
  assign irq_req_ready  = r_tready & w_req_in_range & ~w_pending[irq_req_id];
  assign w_req_fire     = irq_req_valid & irq_req_ready;

  // Only the id field of tdata takes part in matching.
  assign w_rsp_id       = s_if.rsp.tdata[IRQ_RSP_ID_LSB +: ID_W];
  assign w_rsp_in_range = (32'(w_rsp_id) < 32'(NUM_IRQS));
  assign w_rsp_fire     = s_if.rsp.tvalid & r_tready;
  assign w_rsp_match    = w_rsp_fire & w_rsp_in_range & w_pending[w_rsp_id];
  assign w_rsp_unexp    = w_rsp_fire & ~w_rsp_match;

  // One-hot set/clear strobes for the per-vector trackers.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      w_set[i] = w_req_fire  & (irq_req_id == ID_W'(i));
      w_clr[i] = w_rsp_match & (w_rsp_id   == ID_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_IRQS; g++) begin : g_vec
    irq_rsp_vec_tracker #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_vec (
      .clk           (clk),
      .i_rst_n       (rst_n),
      .i_set         (w_set[g]),
      .i_clr         (w_clr[g]),
      .o_pending     (w_pending[g]),
      .o_ack         (w_ack[g]),
      .o_timeout_evt (w_timeout_evt[g])
    );
  end

  // Stream ready and sticky error state; a new error beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tready      <= 1'b0;
      r_err_unexp   <= 1'b0;
      r_err_id      <= '0;
      r_err_timeout <= '0;
    end else begin
      r_tready <= 1'b1;
      if (w_rsp_unexp) begin
        r_err_unexp <= 1'b1;
        if (!r_err_unexp || err_clr) begin
          r_err_id <= s_if.rsp.tdata;
        end
      end else if (err_clr) begin
        r_err_unexp <= 1'b0;
        r_err_id    <= '0;
      end
      r_err_timeout <= (err_clr ? '0 : r_err_timeout) | w_timeout_evt;
    end
  end

  assign s_if_tready   = r_tready;
  assign irq_ack       = w_ack;
  assign irq_pending   = w_pending;
  assign err_unexp_rsp = r_err_unexp;
  assign err_unexp_id  = r_err_id;
  assign err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_irq_rsp_tracker.sv
// Self-checking bench for irq_rsp_tracker: directed scenarios followed by
// random traffic, all compared against a cycle-numbered reference model.
module tb_irq_rsp_tracker;
  import ofs_fim_if_pkg::*;

  localparam int NUM = 4;
  localparam int TO  = 16;

  logic            clk;
  logic            rst_n;
  logic            irq_req_valid;
  logic [1:0]      irq_req_id;
  logic            irq_req_ready;
  logic            s_if_tready;
  logic [NUM-1:0]  irq_ack;
  logic [NUM-1:0]  irq_pending;
  logic            err_clr;
  logic            err_unexp_rsp;
  logic [15:0]     err_unexp_id;
  logic [NUM-1:0]  err_timeout;

  irq_rsp_tracker_if s_if ();

  irq_rsp_tracker #(.NUM_IRQS(NUM), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_req_valid (irq_req_valid),
    .irq_req_id    (irq_req_id),
    .irq_req_ready (irq_req_ready),
    .s_if          (s_if),
    .s_if_tready   (s_if_tready),
    .irq_ack       (irq_ack),
    .irq_pending   (irq_pending),
    .err_clr       (err_clr),
    .err_unexp_rsp (err_unexp_rsp),
    .err_unexp_id  (err_unexp_id),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: pending set with the cycle each request was accepted.
  logic [NUM-1:0] m_pend;
  int             m_since [NUM];
  logic [NUM-1:0] m_ack;
  logic [NUM-1:0] m_to_err;
  logic           m_unexp;
  logic [15:0]    m_unexp_id;
  logic           m_rdy_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_pend = '0; m_ack = '0; m_to_err = '0;
    m_unexp = 1'b0; m_unexp_id = '0; m_rdy_en = 1'b0;
    for (int i = 0; i < NUM; i++) m_since[i] = 0;
  endtask

  task automatic chk_outputs();
    chk("pending", 64'(irq_pending), 64'(m_pend));
    chk("ack", 64'(irq_ack), 64'(m_ack));
    chk("tready", 64'(s_if_tready), 64'(m_rdy_en));
    chk("err_unexp", 64'(err_unexp_rsp), 64'(m_unexp));
    chk("err_id", 64'(err_unexp_id), 64'(m_unexp_id));
    chk("err_timeout", 64'(err_timeout), 64'(m_to_err));
  endtask

  // One clock cycle: check state at the negedge, drive inputs, check ready,
  // advance the model by the rules, then move to the next negedge.
  task automatic step(input logic rv, input logic [1:0] rid, input logic tv,
                      input logic [15:0] td, input logic clr);
    logic [NUM-1:0] pend_n, ack_n, to_n;
    logic           exp_rdy, fire, match;
    logic [1:0]     rsp_id;
    chk_outputs();
    irq_req_valid   = rv;
    irq_req_id      = rid;
    s_if.rsp.tvalid = tv;
    s_if.rsp.tdata  = td;
    err_clr         = clr;
    #1;
    exp_rdy = m_rdy_en && !m_pend[rid];
    chk("req_ready", 64'(irq_req_ready), 64'(exp_rdy));
    rsp_id = td[1:0];
    fire   = tv && m_rdy_en;
    match  = fire && m_pend[rsp_id];
    pend_n = m_pend; ack_n = '0; to_n = '0;
    for (int i = 0; i < NUM; i++) begin
      if (m_pend[i]) begin
        if (match && (int'(rsp_id) == i)) begin
          ack_n[i] = 1'b1; pend_n[i] = 1'b0;
        end else if (cyc - m_since[i] == TO) begin
          to_n[i] = 1'b1; pend_n[i] = 1'b0;
        end
      end
    end
    if (rv && exp_rdy) begin
      pend_n[rid]  = 1'b1;
      m_since[rid] = cyc;
    end
    if (fire && !match) begin
      if (!m_unexp || clr) m_unexp_id = td;
      m_unexp = 1'b1;
    end else if (clr) begin
      m_unexp = 1'b0; m_unexp_id = '0;
    end
    m_to_err = (clr ? '0 : m_to_err) | to_n;
    m_pend   = pend_n;
    m_ack    = ack_n;
    m_rdy_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pending"}, 64'(irq_pending), 64'd0);
    chk({tag, "_ack"}, 64'(irq_ack), 64'd0);
    chk({tag, "_tready"}, 64'(s_if_tready), 64'd0);
    chk({tag, "_ready"}, 64'(irq_req_ready), 64'd0);
    chk({tag, "_unexp"}, 64'(err_unexp_rsp), 64'd0);
    chk({tag, "_id"}, 64'(err_unexp_id), 64'd0);
    chk({tag, "_timeout"}, 64'(err_timeout), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; irq_req_valid = 1'b0; irq_req_id = 2'd0; err_clr = 1'b0;
    s_if.rsp.tvalid = 1'b0; s_if.rsp.tdata = 16'd0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // 1: request id2, response five cycles later
    idle(2);
    step(1'b1, 2'd2, 1'b0, 16'd0, 1'b0);
    idle(4);
    step(1'b0, 2'd0, 1'b1, 16'h0002, 1'b0);
    chk("t1_ack", 64'(irq_ack), 64'h4);
    idle(2);

    // 2: unexpected responses, first id captured, then clear
    step(1'b0, 2'd0, 1'b1, 16'h0001, 1'b0);
    step(1'b0, 2'd0, 1'b1, 16'h0003, 1'b0);
    chk("t2_id", 64'(err_unexp_id), 64'h1);
    step(1'b0, 2'd0, 1'b0, 16'd0, 1'b1);
    chk("t2_clr", 64'(err_unexp_rsp), 64'h0);

    // 3: timeout on id0, then a late response is unexpected
    step(1'b1, 2'd0, 1'b0, 16'd0, 1'b0);
    idle(TO + 2);
    chk("t3_timeout", 64'(err_timeout), 64'h1);
    step(1'b0, 2'd0, 1'b1, 16'h0000, 1'b0);
    step(1'b0, 2'd0, 1'b0, 16'd0, 1'b1);

    // 4: response on the exact expiry cycle wins over the timeout
    step(1'b1, 2'd0, 1'b0, 16'd0, 1'b0);
    idle(TO - 1);
    step(1'b0, 2'd0, 1'b1, 16'hA500, 1'b0);
    chk("t4_ack", 64'(irq_ack), 64'h1);
    idle(1);
    chk("t4_no_timeout", 64'(err_timeout), 64'h0);

    // 5: all four outstanding, out-of-order back-to-back responses
    for (int i = 0; i < NUM; i++) step(1'b1, 2'(i), 1'b0, 16'd0, 1'b0);
    step(1'b1, 2'd3, 1'b1, 16'h0003, 1'b0);
    step(1'b1, 2'd3, 1'b1, 16'h0001, 1'b0);
    step(1'b0, 2'd0, 1'b1, 16'h0000, 1'b0);
    step(1'b0, 2'd0, 1'b1, 16'h0002, 1'b0);
    idle(2);
    step(1'b0, 2'd0, 1'b1, 16'h0003, 1'b0);
    idle(1);

    // 6: asynchronous reset with two vectors pending
    step(1'b1, 2'd1, 1'b0, 16'd0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 16'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    s_if.rsp.tvalid = 1'b1; s_if.rsp.tdata = 16'h0001;
    repeat (2) @(negedge clk);
    chk_all_zero("in_rst");
    m_reset();
    rst_n = 1'b1;
    idle(2);

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 3), 16'($urandom()),
           ($urandom_range(0, 19) == 0));
    end
    idle(TO + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
